// File: rtl/axil_mem_test_engine.sv
// axil_mem_test_engine: AXI4-Lite controlled RAM fill/verify engine with cycle, word and error counters
module axil_mem_test_engine #(
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_DATA_W = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int CNT_W = 32
) (
  input  logic                            iclk,
  input  logic                            irst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            o_busy,
  output logic                            o_done
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [31:0] SEED = 32'hACE1_0001;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] ctrl, count_max, wmask, ctrl_new, rd_val, p32, lfsr;
  logic [CNT_W-1:0] set_cnt, clk_cnt, err_cnt;
  logic [AW-1:0] addr, last;
  logic [MEM_DATA_W-1:0] mem [MEM_DEPTH];
  logic [MEM_DATA_W-1:0] ram_q, exp_q, pat;
  logic [2:0] widx, ridx;
  logic wr_en, rd_en, ctrl_wr, start, abort, last_word, mode, cmp_v, done, unused;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return x + CNT_W'(x != '1);
  endfunction
  assign unused = ^{s_axi_awaddr, s_axi_araddr};
  assign widx = s_axi_awaddr[4:2];
  assign ridx = s_axi_araddr[4:2];
  assign wr_en = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign rd_en = s_axi_arready & s_axi_arvalid;
  assign wmask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign ctrl_new = (ctrl & ~wmask) | (s_axi_wdata & wmask);
  assign ctrl_wr = wr_en && widx == 3'd0 && s_axi_wstrb[0];
  assign start = ctrl_wr && state == IDLE && (ctrl_new[1:0] == 2'd1 || ctrl_new[1:0] == 2'd2);
  assign abort = ctrl_wr && o_busy && ctrl_new[1:0] == 2'd3;
  assign o_busy = state == WRITE || state == READ || state == DRAIN;
  assign o_done = done;
  assign last_word = addr == last;
  assign p32 = mode ? lfsr : 32'(addr);
  assign pat = MEM_DATA_W'(p32);
  assign s_axi_wready = s_axi_awready;
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign rd_val = ridx == 3'd0 ? ctrl :
                  ridx == 3'd1 ? count_max :
                  ridx == 3'd2 ? 32'(set_cnt) :
                  ridx == 3'd3 ? 32'(clk_cnt) :
                  ridx == 3'd4 ? {29'd0, err_cnt != '0, done, o_busy} :
                  ridx == 3'd5 ? 32'(err_cnt) : '0;
  always_comb begin
    state_nxt = abort ? IDLE :
                start ? (ctrl_new[1:0] == 2'd1 ? WRITE : READ) :
                (state == WRITE && last_word) ? DONE :
                (state == READ && last_word) ? DRAIN :
                state == DRAIN ? DONE :
                state == DONE ? IDLE : state;
  end
  always_ff @(posedge iclk) begin
    if (irst) begin
      s_axi_awready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      ctrl <= '0;
      count_max <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
      s_axi_bvalid <= wr_en | (s_axi_bvalid & ~s_axi_bready);
      s_axi_arready <= s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;
      s_axi_rvalid <= rd_en | (s_axi_rvalid & ~s_axi_rready);
      if (rd_en) s_axi_rdata <= rd_val;
      if (wr_en && widx == 3'd0) ctrl <= ctrl_new;
      if (wr_en && widx == 3'd1) count_max <= (count_max & ~wmask) | (s_axi_wdata & wmask);
    end
  end
  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= IDLE;
      set_cnt <= '0;
      clk_cnt <= '0;
      err_cnt <= '0;
      done <= 1'b0;
      addr <= '0;
      last <= '0;
      lfsr <= SEED;
      mode <= 1'b0;
      cmp_v <= 1'b0;
      exp_q <= '0;
    end else begin
      state <= state_nxt;
      cmp_v <= state == READ;
      exp_q <= pat;
      if (start) begin
        set_cnt <= '0;
        clk_cnt <= '0;
        done <= 1'b0;
        addr <= '0;
        lfsr <= SEED;
        mode <= ctrl_new[2];
        last <= count_max > 32'(MEM_DEPTH - 1) ? '1 : count_max[AW-1:0];
        if (ctrl_new[1:0] == 2'd2) err_cnt <= '0;
      end
      if (o_busy) clk_cnt <= sat_inc(clk_cnt);
      if (state == WRITE || state == READ) begin
        addr <= addr + 1'b1;
        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      end
      if (state == WRITE) set_cnt <= sat_inc(set_cnt);
      if (cmp_v && (state == READ || state == DRAIN)) begin
        set_cnt <= sat_inc(set_cnt);
        if (ram_q != exp_q) err_cnt <= sat_inc(err_cnt);
      end
      if (state == DONE) done <= 1'b1;
    end
  end
  always_ff @(posedge iclk) begin
    if (state == WRITE) mem[addr] <= pat;
    ram_q <= mem[addr];
  end
endmodule

// File: tb/tb_axil_mem_test_engine.sv
// tb_axil_mem_test_engine: scoreboard bench for the AXI-Lite memory test engine
module tb_axil_mem_test_engine;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  logic iclk = 1'b0, irst = 1'b1;
  logic [4:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b1;
  logic s_axi_arvalid = 1'b0, s_axi_rready = 1'b1;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, o_busy, o_done;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  int checks = 0, failures = 0, busy_total = 0, exp_err = 0;
  logic [31:0] mm [1024];
  logic [31:0] exp_q [$];
  string tag_q [$];
  axil_mem_test_engine dut (
    .iclk(iclk), .irst(irst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .o_busy(o_busy), .o_done(o_done)
  );
  always #5 iclk = ~iclk;
  always @(posedge iclk) if (o_busy) busy_total <= busy_total + 1;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin @(posedge iclk); #1; end
  endtask
  task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    while (!s_axi_awready && t < 50) begin tick(1); t++; end
    if (t >= 50) chk("aw_timeout", 32'(s_axi_awready), 32'd1);
    tick(1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin tick(1); t++; end
    if (t >= 50) chk("b_timeout", 32'(s_axi_bvalid), 32'd1);
    else if (s_axi_bresp != 2'b00) chk("bresp", 32'(s_axi_bresp), 32'd0);
    tick(1);
  endtask
  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
    int t = 0;
    logic [31:0] x;
    string tg;
    exp_q.push_back(e); tag_q.push_back(tag);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && t < 50) begin tick(1); t++; end
    tick(1);
    s_axi_arvalid = 1'b0;
    t = 0;
    while (!s_axi_rvalid && t < 50) begin tick(1); t++; end
    x = exp_q.pop_front(); tg = tag_q.pop_front();
    if (!s_axi_rvalid) chk({tg, "_r_timeout"}, 32'(s_axi_rvalid), 32'd1);
    else begin
      chk(tg, s_axi_rdata, x);
      if (s_axi_rresp != 2'b00) chk({tg, "_rresp"}, 32'(s_axi_rresp), 32'd0);
    end
    tick(1);
  endtask
  task automatic wait_done();
    int t = 0;
    while (!o_done && t < 3000) begin tick(1); t++; end
    if (!o_done) chk("done_timeout", 32'(o_done), 32'd1);
  endtask
  task automatic run_op(input logic [31:0] cm, input logic [2:0] c, input string tag);
    int n, base, e;
    logic [31:0] s, p;
    n = (cm > 32'd1023) ? 1024 : int'(cm) + 1;
    s = SEED; e = 0;
    for (int i = 0; i < n; i++) begin
      p = c[2] ? s : 32'(i);
      if (c[1:0] == 2'd1) mm[i] = p;
      else if (mm[i] !== p) e++;
      s = lfsr_next(s);
    end
    if (c[1:0] == 2'd2) exp_err = e;
    base = busy_total;
    axi_wr(5'h00, {29'd0, c}, 4'hF);
    wait_done();
    chk({tag, "_busy_cycles"}, 32'(busy_total - base), 32'(c[1:0] == 2'd1 ? n : n + 1));
    chk({tag, "_o_done"}, 32'(o_done), 32'd1);
    rd(5'h08, 32'(n), {tag, "_set"});
    rd(5'h0C, 32'(c[1:0] == 2'd1 ? n : n + 1), {tag, "_clk"});
    rd(5'h14, 32'(exp_err), {tag, "_err"});
    rd(5'h10, {29'd0, exp_err != 0, 2'b10}, {tag, "_status"});
  endtask
  initial begin
    int base, n, acc;
    tick(3);
    irst = 1'b0;
    tick(1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    for (int i = 0; i < 6; i++) rd(5'(i * 4), 32'd0, $sformatf("rst_reg%0d", i));
    axi_wr(5'h00, 32'd0, 4'hF);
    axi_wr(5'h04, 32'd0, 4'hF);
    run_op(32'd0, 3'd1, "w1");
    axi_wr(5'h04, 32'd15, 4'hF);
    run_op(32'd15, 3'd1, "w16");
    run_op(32'd15, 3'd2, "r16");
    axi_wr(5'h04, 32'd5000, 4'hF);
    run_op(32'd5000, 3'd1, "wfull");
    run_op(32'd5000, 3'd2, "rfull");
    axi_wr(5'h04, 32'd7, 4'hF);
    run_op(32'd7, 3'd1, "w8inc");
    run_op(32'd7, 3'd6, "r8lfsr");
    chk("r8lfsr_errs", 32'(exp_err), 32'd8);
    run_op(32'd7, 3'd5, "w8lfsr");
    run_op(32'd7, 3'd6, "r8lfsr_ok");
    run_op(32'd7, 3'd2, "r8inc_bad");
    axi_wr(5'h04, 32'd1023, 4'hF);
    base = busy_total;
    axi_wr(5'h00, 32'd1, 4'hF);
    tick(100);
    axi_wr(5'h00, 32'd2, 4'hF);
    chk("ab_still_busy", 32'(o_busy), 32'd1);
    rd(5'h00, 32'd2, "ab_ctrl_stored");
    axi_wr(5'h00, 32'd3, 4'hF);
    chk("ab_busy_low", 32'(o_busy), 32'd0);
    chk("ab_done", 32'(o_done), 32'd0);
    n = busy_total - base;
    chk("ab_partial", 32'(n > 0 && n < 1024), 32'd1);
    for (int i = 0; i < n; i++) mm[i] = 32'(i);
    tick(20);
    rd(5'h08, 32'(n), "ab_set_frozen");
    rd(5'h0C, 32'(n), "ab_clk_frozen");
    rd(5'h10, {29'd0, exp_err != 0, 2'b00}, "ab_status");
    rd(5'h18, 32'd0, "unmapped_rd");
    axi_wr(5'h1C, 32'hFFFF_FFFF, 4'hF);
    rd(5'h00, 32'd3, "unmapped_wr");
    axi_wr(5'h00, 32'd0, 4'hF);
    base = busy_total;
    axi_wr(5'h00, 32'd1, 4'h0);
    tick(5);
    chk("strb0_nostart", 32'(busy_total - base), 32'd0);
    rd(5'h00, 32'd0, "strb0_ctrl");
    axi_wr(5'h04, 32'd3, 4'hF);
    axi_wr(5'h04, 32'h1234_5678, 4'b0101);
    rd(5'h04, 32'h0034_0078, "wstrb_bytes");
    s_axi_bready = 1'b0;
    s_axi_awaddr = 5'h04; s_axi_wdata = 32'd3; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    acc = 0;
    while (!s_axi_awready && acc < 50) begin tick(1); acc++; end
    tick(1);
    s_axi_wdata = 32'd9;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_axi_awready) acc++;
      tick(1);
    end
    chk("bhold_bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("bhold_no_accept", 32'(acc), 32'd0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    tick(1);
    chk("bhold_release", 32'(s_axi_bvalid), 32'd0);
    rd(5'h04, 32'd3, "bhold_cm");
    axi_wr(5'h04, 32'd1023, 4'hF);
    axi_wr(5'h00, 32'd1, 4'hF);
    tick(50);
    chk("midrst_busy_pre", 32'(o_busy), 32'd1);
    irst = 1'b1;
    tick(1);
    irst = 1'b0;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
    for (int i = 0; i < 6; i++) rd(5'(i * 4), 32'd0, $sformatf("midrst_reg%0d", i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
